fft_scan_ctrl: RTL and testbench

FFT_SCAN_CTRL -- requirements
Module: fft_scan_ctrl

---
 rtl/fft_ctrl_pkg.sv | 25 ++
 rtl/idx_delay.sv | 62 ++++++
 rtl/fft_scan_ctrl.sv | 115 +++++++++++
 tb/tb_fft_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types, defaults and widths for the FFT bin-pair scan controller.
package fft_ctrl_pkg;

    localparam int unsigned DEF_NUM_PAIRS = 256;
    localparam int unsigned DEF_RD_LAT    = 2;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned SIDX_W = 9;
    localparam int unsigned PEAK_W = 10;
    localparam int unsigned CNT_W  = 16;

    // bit8 set marks hold/terminal to the peak detector; all-zero clears it
    localparam logic [SIDX_W-1:0] SCAN_HOLD  = 9'h100;
    localparam logic [SIDX_W-1:0] SCAN_CLEAR = 9'h000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_DRAIN,
        ST_TERM,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/idx_delay.sv
// Aligns the read address with RAM data LAT cycles later and forms scan_index.
module idx_delay
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              clr,
    output logic [SIDX_W-1:0] scan_index
);

    logic              tap_vld;
    logic [ADDR_W-1:0] tap_addr;

    // LAT-1 internal stages; the scan_index register supplies the last one
    generate
        if (LAT > 1) begin : g_pipe
            logic [LAT-2:0]    vld_q;
            logic [ADDR_W-1:0] addr_q [LAT-1];

            // Shift valid/address down the pipe; reset invalidates every stage
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < int'(LAT) - 1; i++) begin
                        addr_q[i] <= '0;
                    end
                end else begin
                    vld_q[0]  <= in_vld;
                    addr_q[0] <= in_addr;
                    for (int i = 1; i < int'(LAT) - 1; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        addr_q[i] <= addr_q[i-1];
                    end
                end
            end

            assign tap_vld  = vld_q[LAT-2];
            assign tap_addr = addr_q[LAT-2];
        end else begin : g_direct
            assign tap_vld  = in_vld;
            assign tap_addr = in_addr;
        end
    endgenerate

    // Final stage: clear pulse for the detector, delayed address, or hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_index <= SCAN_HOLD;
        end else if (clr) begin
            scan_index <= SCAN_CLEAR;
        end else if (tap_vld) begin
            scan_index <= {1'b0, tap_addr};
        end else begin
            scan_index <= SCAN_HOLD;
        end
    end

endmodule

// File: rtl/fft_scan_ctrl.sv
// Per-frame scan of the FFT output RAM and peak-bin report handshake.
module fft_scan_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PAIRS = DEF_NUM_PAIRS,
    parameter int unsigned RD_LAT    = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [SIDX_W-1:0] scan_index,
    input  logic [PEAK_W-1:0] det_idx,
    output logic [PEAK_W-1:0] peak_idx,
    output logic              peak_valid,
    input  logic              peak_ready,
    output logic              busy,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned      LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PAIRS - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(RD_LAT - 1);

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic             start_c;

    assign start_c = (state == ST_IDLE) && frame_ready;

    // Frame sequencer; every output is set on the edge entering its state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            peak_idx   <= '0;
            peak_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            // Any frame arriving while not idle (including the accept cycle) is dropped
            if (frame_ready && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_ready) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state   <= ST_SCAN;
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                end
                ST_SCAN: begin
                    if (rd_addr == LAST_ADDR) begin
                        state   <= ST_DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        lat_cnt <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (lat_cnt == LAST_LAT) begin
                        state <= ST_TERM;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_TERM: begin
                    peak_idx   <= det_idx;
                    peak_valid <= 1'b1;
                    state      <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (peak_ready) begin
                        peak_valid <= 1'b0;
                        frame_cnt  <= frame_cnt + 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    rd_en      <= 1'b0;
                    rd_addr    <= '0;
                    peak_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    idx_delay #(
        .LAT (RD_LAT)
    ) u_idx_delay (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_vld     (rd_en),
        .in_addr    (rd_addr),
        .clr        (start_c),
        .scan_index (scan_index)
    );

endmodule

// File: tb/tb_fft_scan_ctrl.sv
// Directed bench for fft_scan_ctrl at default parameters.
module tb_fft_scan_ctrl;
    import fft_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_ready;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [8:0]  scan_index;
    logic [9:0]  det_idx;
    logic [9:0]  peak_idx;
    logic        peak_valid;
    logic        peak_ready;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_p1;
    logic [7:0] ram_data;

    always #5 clk = ~clk;

    // RAM model: returns the requested address two cycles later
    always @(posedge clk) begin
        ram_p1   <= rd_addr;
        ram_data <= ram_p1;
    end

    fft_scan_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_ready (frame_ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .scan_index  (scan_index),
        .det_idx     (det_idx),
        .peak_idx    (peak_idx),
        .peak_valid  (peak_valid),
        .peak_ready  (peak_ready),
        .busy        (busy),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse frame_ready (cycle 0) and return the cycle where peak_valid first shows
    task automatic run_frame(output int cyc);
        frame_ready = 1'b1;
        cyc = 0;
        step();
        frame_ready = 1'b0;
        cyc = 1;
        while (!peak_valid && cyc < 1000) begin
            step();
            cyc++;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_busy"},       32'(busy),       32'd0);
        check({pfx, "_rd_en"},      32'(rd_en),      32'd0);
        check({pfx, "_rd_addr"},    32'(rd_addr),    32'd0);
        check({pfx, "_scan_index"}, 32'(scan_index), 32'h100);
        check({pfx, "_peak_idx"},   32'(peak_idx),   32'd0);
        check({pfx, "_peak_valid"}, 32'(peak_valid), 32'd0);
        check({pfx, "_overrun"},    32'(overrun),    32'd0);
        check({pfx, "_frame_cnt"},  32'(frame_cnt),  32'd0);
    endtask

    initial begin
        int cyc;
        int bad;
        int sbad;
        int nrd;

        reset_n     = 1'b0;
        frame_ready = 1'b0;
        peak_ready  = 1'b0;
        det_idx     = '0;
        repeat (3) step();
        check_reset_values("rst");
        reset_n = 1'b1;
        step();

        // Single frame, consumer always ready
        det_idx    = 10'd37;
        peak_ready = 1'b1;
        run_frame(cyc);
        check("t1_latency", 32'(cyc), 32'd261);
        check("t1_peak_idx", 32'(peak_idx), 32'd37);
        step();
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_valid_drop", 32'(peak_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_overrun", 32'(overrun), 32'd0);

        // Address sequence and scan_index alignment with RAM data
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("seq_clear_idx", 32'(scan_index), 32'd0);
        check("seq_clear_busy", 32'(busy), 32'd1);
        check("seq_clear_rd_en", 32'(rd_en), 32'd0);
        bad = 0; sbad = 0; nrd = 0;
        for (int c = 2; c <= 260; c++) begin
            logic       e_en;
            logic [7:0] e_addr;
            logic [8:0] e_scan;
            step();
            e_en   = (c >= 2 && c <= 257);
            e_addr = e_en ? 8'(c - 2) : 8'd0;
            e_scan = (c >= 4 && c <= 259) ? 9'(c - 4) : 9'h100;
            if (rd_en !== e_en || rd_addr !== e_addr || scan_index !== e_scan) bad++;
            if (rd_en) nrd++;
            if (scan_index[8] == 1'b0 && scan_index[7:0] !== ram_data) sbad++;
        end
        check("seq_addr_scan", 32'(bad), 32'd0);
        check("seq_ram_align", 32'(sbad), 32'd0);
        check("seq_rd_count", 32'(nrd), 32'd256);
        step();
        check("seq_valid_261", 32'(peak_valid), 32'd1);
        step();
        check("seq_frame_cnt", 32'(frame_cnt), 32'd2);

        // Overrun: second frame_ready at SCAN address 100
        check("ovr_pre", 32'(overrun), 32'd0);
        det_idx = 10'd200;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        cyc = 1;
        while (!(rd_en && rd_addr == 8'd100) && cyc < 400) begin
            step();
            cyc++;
        end
        check("ovr_hit_cycle", 32'(cyc), 32'd102);
        frame_ready = 1'b1;
        step();
        cyc++;
        frame_ready = 1'b0;
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_scan_cont", 32'(rd_addr), 32'd101);
        while (!peak_valid && cyc < 1000) begin
            step();
            cyc++;
        end
        check("ovr_latency", 32'(cyc), 32'd261);
        check("ovr_peak_idx", 32'(peak_idx), 32'd200);
        step();
        check("ovr_frame_cnt", 32'(frame_cnt), 32'd3);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (peak_valid || busy) bad++;
        end
        check("ovr_one_report", 32'(bad), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_cnt_after", 32'(frame_cnt), 32'd3);

        // Reset in the middle of a scan
        det_idx = 10'd37;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        cyc = 1;
        while (!(rd_en && rd_addr == 8'd128) && cyc < 400) begin
            step();
            cyc++;
        end
        check("mrst_hit_cycle", 32'(cyc), 32'd130);
        reset_n = 1'b0;
        step();
        check_reset_values("mrst");
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (scan_index !== 9'h100 || busy || peak_valid) bad++;
        end
        check("mrst_quiet", 32'(bad), 32'd0);
        run_frame(cyc);
        check("mrst_latency", 32'(cyc), 32'd261);
        check("mrst_peak_idx", 32'(peak_idx), 32'd37);
        step();
        check("mrst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Backpressure, then frame_ready on the accepting cycle
        peak_ready = 1'b0;
        det_idx = 10'd500;
        run_frame(cyc);
        check("bp_latency", 32'(cyc), 32'd261);
        check("bp_peak_idx", 32'(peak_idx), 32'd500);
        det_idx = 10'd99;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!peak_valid || peak_idx !== 10'd500 || frame_cnt !== 16'd1) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        check("bp_pre_ovr", 32'(overrun), 32'd0);
        peak_ready  = 1'b1;
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("bp_accept_cnt", 32'(frame_cnt), 32'd2);
        check("bp_valid_drop", 32'(peak_valid), 32'd0);
        check("bp_hs_overrun", 32'(overrun), 32'd1);
        check("bp_idle", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy || scan_index !== 9'h100) bad++;
        end
        check("bp_frame_dropped", 32'(bad), 32'd0);

        // frame_cnt wrap
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        check("wrap_preload", 32'(frame_cnt), 32'hFFFF);
        det_idx = 10'd37;
        run_frame(cyc);
        check("wrap_latency", 32'(cyc), 32'd261);
        step();
        check("wrap_frame_cnt", 32'(frame_cnt), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
